button_event_decoder: RTL and testbench

- Sits directly downstream of the per-button debouncers in the control unit and consumes their stable, active-high button levels.
- Classifies each press as SHORT (released before a hold threshold) or LONG (held up to the threshold).
- Queues the classified events in a small FIFO and presents them to the control-unit FSM over a valid/ready handshake, one event per transfer.

---
 rtl/button_event_decoder.sv | 194 +++++++++++++++++++
 tb/tb_button_event_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder
//
// Turns debounced, active-high button levels into SHORT/LONG press events.
// Each press is classified by a per-button hold FSM. The event is parked in a
// pending flag and then pushed, one per cycle, into a small FIFO. The FIFO is
// drained by the control-unit FSM over a valid/ready handshake.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   btn_level  debounced button levels (1 = pressed), synchronous to clk
//   evt_ready  consumer takes the head event when high together with evt_valid
//   evt_valid  FIFO non-empty; evt_code is valid
//   evt_code   [IDX_W] = type (0 SHORT, 1 LONG), [IDX_W-1:0] = button index
//   overflow   sticky; set when an event is lost to a pending-flag collision
module button_event_decoder #(
    parameter int unsigned NUM_BTN     = 4,
    parameter int unsigned LONG_CYCLES = 12_000_000,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_level,
    input  logic               evt_ready,
    output logic               evt_valid,
    output logic [IDX_W:0]     evt_code,
    output logic               overflow
);

    localparam int unsigned        PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(LONG_CYCLES - 1);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } state_e;

    // Input stage and edge detection
    logic [NUM_BTN-1:0] lvl_q, prev_q, rise, fall;

    // Per-button hold FSMs
    state_e             st_q  [NUM_BTN];
    state_e             st_d  [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] raise_s, raise_l;

    // Pending flags and sticky overflow
    logic [NUM_BTN-1:0] pend_s_q, pend_s_d, pend_l_q, pend_l_d;
    logic [NUM_BTN-1:0] grant_s, grant_l;
    logic               ovf_q, ovf_d;

    // Event FIFO
    logic [IDX_W:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [PTR_W:0]     fill_q;
    logic               full, empty, push, pop;
    logic [IDX_W:0]     push_code;

    assign rise  = lvl_q & ~prev_q;
    assign fall  = ~lvl_q & prev_q;
    assign full  = (fill_q == FULL_CNT);
    assign empty = (fill_q == '0);
    assign pop   = !empty && evt_ready;

    assign evt_valid = !empty;
    assign evt_code  = mem_q[rd_q];
    assign overflow  = ovf_q;

    // Hold FSM next state. A fall wins over the threshold, so a release on
    // the threshold cycle is still a SHORT press.
    always_comb begin
        raise_s = '0;
        raise_l = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            unique case (st_q[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        st_d[i]  = ST_HELD;
                        cnt_d[i] = '0;
                    end
                end
                ST_HELD: begin
                    if (fall[i]) begin
                        raise_s[i] = 1'b1;
                        st_d[i]    = ST_IDLE;
                    end else if (cnt_q[i] == LAST_CNT) begin
                        raise_l[i] = 1'b1;
                        st_d[i]    = ST_LONG;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_LONG: begin
                    if (fall[i]) begin
                        st_d[i] = ST_IDLE;
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase
        end
    end

    // Arbiter: lowest button first, SHORT before LONG for the same button.
    // A push into a full FIFO is allowed when the head is popped that cycle.
    always_comb begin
        grant_s   = '0;
        grant_l   = '0;
        push      = 1'b0;
        push_code = '0;
        if (!full || pop) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (!push) begin
                    if (pend_s_q[i]) begin
                        grant_s[i] = 1'b1;
                        push       = 1'b1;
                        push_code  = {1'b0, IDX_W'(i)};
                    end else if (pend_l_q[i]) begin
                        grant_l[i] = 1'b1;
                        push       = 1'b1;
                        push_code  = {1'b1, IDX_W'(i)};
                    end
                end
            end
        end
    end

    // Pending flags. A flag granted this cycle is already on its way into the
    // FIFO, so a new event of the same kind may take its place without loss.
    always_comb begin
        pend_s_d = pend_s_q & ~grant_s;
        pend_l_d = pend_l_q & ~grant_l;
        ovf_d    = ovf_q;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (raise_s[i]) begin
                if (pend_s_d[i]) ovf_d = 1'b1;
                pend_s_d[i] = 1'b1;
            end
            if (raise_l[i]) begin
                if (pend_l_d[i]) ovf_d = 1'b1;
                pend_l_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q    <= '0;
            prev_q   <= '0;
            pend_s_q <= '0;
            pend_l_q <= '0;
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            fill_q   <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
            end
            for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            lvl_q    <= btn_level;
            prev_q   <= lvl_q;
            pend_s_q <= pend_s_d;
            pend_l_q <= pend_l_d;
            ovf_q    <= ovf_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            if (push) begin
                mem_q[wr_q] <= push_code;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fill_q <= fill_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                fill_q <= fill_q - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

    localparam int NB = 4;
    localparam int LC = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_level;
    logic          evt_ready;
    logic          evt_valid;
    logic [IW:0]   evt_code;
    logic          overflow;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int          log_cyc[$];
    logic [IW:0] log_code[$];

    typedef struct {
        int         btn;
        int         hold;
        logic [2:0] code;
        bit         is_long;
    } vec_t;

    vec_t vecs[7];

    button_event_decoder #(
        .NUM_BTN    (NB),
        .LONG_CYCLES(LC),
        .CNT_W      (24),
        .FIFO_DEPTH (4),
        .IDX_W      (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_level(btn_level),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted transfer with the edge count at which it became visible
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            log_cyc.push_back(cyc);
            log_code.push_back(evt_code);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_code.delete();
    endtask

    task automatic short_press(input int b);
        btn_level[b] = 1'b1;
        step(2);
        btn_level[b] = 1'b0;
        step(6);
    endtask

    initial begin
        int p;
        int r;
        int exp_cyc;

        vecs[0] = '{btn: 1, hold: 10, code: 3'b001, is_long: 1'b0};
        vecs[1] = '{btn: 2, hold: 40, code: 3'b110, is_long: 1'b1};
        vecs[2] = '{btn: 0, hold: 16, code: 3'b000, is_long: 1'b0};
        vecs[3] = '{btn: 0, hold: 17, code: 3'b100, is_long: 1'b1};
        vecs[4] = '{btn: 3, hold: 1,  code: 3'b011, is_long: 1'b0};
        vecs[5] = '{btn: 2, hold: 5,  code: 3'b010, is_long: 1'b0};
        vecs[6] = '{btn: 1, hold: 20, code: 3'b101, is_long: 1'b1};

        rst       = 1'b1;
        btn_level = '0;
        evt_ready = 1'b1;
        step(3);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_code", 32'(evt_code), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        step(3);
        check("idle_no_events", 32'(log_code.size()), 32'd0);

        // Single presses: SHORT events 3 edges after release, LONG events
        // 3 edges after the threshold is reached (press start + LC + 3).
        foreach (vecs[i]) begin
            clear_log();
            p = cyc;
            btn_level[vecs[i].btn] = 1'b1;
            step(vecs[i].hold);
            r = cyc;
            btn_level[vecs[i].btn] = 1'b0;
            step(8);
            exp_cyc = vecs[i].is_long ? p + LC + 3 : r + 3;
            check($sformatf("v%0d_count", i), 32'(log_code.size()), 32'd1);
            if (log_code.size() > 0) begin
                check($sformatf("v%0d_code", i), 32'(log_code[0]), 32'(vecs[i].code));
                check($sformatf("v%0d_cycle", i), 32'(log_cyc[0]), 32'(exp_cyc));
            end
        end

        // Simultaneous release of buttons 0 and 3: index order, back to back
        clear_log();
        btn_level = 4'b1001;
        step(5);
        r = cyc;
        btn_level = '0;
        step(8);
        check("sim_count", 32'(log_code.size()), 32'd2);
        if (log_code.size() == 2) begin
            check("sim_code0", 32'(log_code[0]), 32'b000);
            check("sim_cycle0", 32'(log_cyc[0]), 32'(r + 3));
            check("sim_code1", 32'(log_code[1]), 32'b011);
            check("sim_cycle1", 32'(log_cyc[1]), 32'(r + 4));
        end

        // Back-pressure: 4 queued + 1 pending, 6th press collides
        clear_log();
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            short_press(1);
            check($sformatf("bp_valid%0d", k), 32'(evt_valid), 32'd1);
            check($sformatf("bp_code%0d", k), 32'(evt_code), 32'b001);
        end
        check("bp_no_overflow", 32'(overflow), 32'd0);
        check("bp_no_transfer", 32'(log_code.size()), 32'd0);
        short_press(1);
        check("bp_overflow", 32'(overflow), 32'd1);
        evt_ready = 1'b1;
        step(10);
        check("drain_count", 32'(log_code.size()), 32'd5);
        foreach (log_code[k]) begin
            check($sformatf("drain_code%0d", k), 32'(log_code[k]), 32'b001);
        end
        check("drain_empty", 32'(evt_valid), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-hold with two queued events and overflow set
        clear_log();
        evt_ready = 1'b0;
        short_press(1);
        short_press(3);
        check("pre_rst_valid", 32'(evt_valid), 32'd1);
        check("pre_rst_code", 32'(evt_code), 32'b001);
        btn_level[2] = 1'b1;
        step(6);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_code", 32'(evt_code), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        step(2);
        rst = 1'b0;
        evt_ready = 1'b1;
        clear_log();
        step(5);
        r = cyc;
        btn_level[2] = 1'b0;
        step(8);
        check("post_rst_count", 32'(log_code.size()), 32'd1);
        if (log_code.size() > 0) begin
            check("post_rst_code", 32'(log_code[0]), 32'b010);
            check("post_rst_cycle", 32'(log_cyc[0]), 32'(r + 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
